// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-imem and fetch-to-decoder signal bundle.
// The master modport is the fetch unit; the slave modport is memory, redirect source and decoder.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_rdata;
  logic                  imem_valid;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  id_ready;
  logic                  if_valid;
  logic [31:0]           instr;
  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic [ADDR_WIDTH-1:0] pc_out;
  logic [ADDR_WIDTH-1:0] pc_plus4;

  modport master (
    output imem_req, imem_addr, if_valid, instr, opcode, funct, pc_out, pc_plus4,
    input  imem_rdata, imem_valid, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, instr, opcode, funct, pc_out, pc_plus4,
    output imem_rdata, imem_valid, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, issues one imem request at a time and presents the returned
// word to the decoder with a valid/ready handshake; accepts redirects from later stages.
module instr_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input logic                clk,
  input logic                reset,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_nxt;
  logic                  redir;
  logic                  imem_req_q;
  logic [ADDR_WIDTH-1:0] imem_addr_q;
  logic                  if_valid_q;
  logic [31:0]           instr_q;
  logic [ADDR_WIDTH-1:0] pc_out_q;
  logic [ADDR_WIDTH-1:0] pc_plus4_q;

  assign redir = bus.redirect_valid && (state != IDLE);

  // Redirect takes priority over the decoder consuming the held instruction.
  always_comb begin
    pc_nxt = pc;
    if (redir) begin
      pc_nxt = bus.redirect_pc & ALIGN_MASK;
    end else if (state == HOLD && bus.id_ready) begin
      pc_nxt = pc + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      if_valid_q  <= 1'b0;
      instr_q     <= '0;
      pc_out_q    <= '0;
      pc_plus4_q  <= '0;
    end else begin
      pc         <= pc_nxt;
      imem_req_q <= 1'b0;
      unique case (state)
        IDLE: begin
          state       <= REQ;
          imem_req_q  <= 1'b1;
          imem_addr_q <= pc_nxt;
        end
        REQ: begin
          // A redirect here cancels the request already on the bus; its response must be drained.
          state <= redir ? DRAIN : WAIT;
        end
        WAIT: begin
          if (bus.imem_valid) begin
            if (redir) begin
              state       <= REQ;
              imem_req_q  <= 1'b1;
              imem_addr_q <= pc_nxt;
            end else begin
              instr_q    <= bus.imem_rdata;
              pc_out_q   <= pc;
              pc_plus4_q <= pc + PC_STEP;
              if_valid_q <= 1'b1;
              state      <= HOLD;
            end
          end else if (redir) begin
            state <= DRAIN;
          end
        end
        HOLD: begin
          if (redir || bus.id_ready) begin
            if_valid_q  <= 1'b0;
            state       <= REQ;
            imem_req_q  <= 1'b1;
            imem_addr_q <= pc_nxt;
          end
        end
        DRAIN: begin
          // The stale response retires the cancelled request even if another redirect lands with it.
          if (bus.imem_valid) begin
            state       <= REQ;
            imem_req_q  <= 1'b1;
            imem_addr_q <= pc_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = imem_addr_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.instr     = instr_q;
  assign bus.opcode    = instr_q[31:26];
  assign bus.funct     = instr_q[5:0];
  assign bus.pc_out    = pc_out_q;
  assign bus.pc_plus4  = pc_plus4_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: variable-latency imem model, transaction-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_instr_fetch_unit;

  logic clk;
  logic reset;

  instr_fetch_unit_if #(.ADDR_WIDTH(32)) bus ();

  instr_fetch_unit #(
    .ADDR_WIDTH(32),
    .RESET_PC  (32'h0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned lat    = 1;
  int unsigned tcyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h8) return 32'h8C020004;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction memory: one response per request, lat cycles after the request cycle.
  initial begin
    logic        pend;
    logic [31:0] paddr;
    int unsigned cnt;
    pend = 1'b0;
    paddr = '0;
    cnt = 0;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.imem_valid = 1'b0;
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            bus.imem_valid = 1'b1;
            bus.imem_rdata = memword(paddr);
            pend = 1'b0;
          end
        end
        if (bus.imem_req === 1'b1) begin
          pend = 1'b1;
          paddr = bus.imem_addr;
          cnt = lat;
        end
      end
    end
  end

  // Reference model: expected fetch PC, one outstanding request (live or cancelled),
  // and at most one word presented to the decoder.
  initial begin
    logic        started, rst_q;
    logic        m_req, m_out, m_live, m_have;
    logic [31:0] m_pc, m_oaddr, m_waddr, w;
    started = 1'b0; rst_q = 1'b0;
    m_req = 1'b0; m_out = 1'b0; m_live = 1'b0; m_have = 1'b0;
    m_pc = '0; m_oaddr = '0; m_waddr = '0; w = '0;
    forever begin
      @(negedge clk);
      if (started) begin
        if (rst_q) begin
          chk("rst_if_valid", 32'(bus.if_valid), 32'h0);
          chk("rst_imem_req", 32'(bus.imem_req), 32'h0);
          chk("rst_instr", bus.instr, 32'h0);
          chk("rst_opcode", 32'(bus.opcode), 32'h0);
          chk("rst_funct", 32'(bus.funct), 32'h0);
          chk("rst_pc_out", bus.pc_out, 32'h0);
          chk("rst_pc_plus4", bus.pc_plus4, 32'h0);
        end else begin
          chk("imem_req", 32'(bus.imem_req), 32'(m_req));
          if (m_req) chk("imem_addr", bus.imem_addr, m_pc);
          chk("if_valid", 32'(bus.if_valid), 32'(m_have));
          if (m_have) begin
            w = memword(m_waddr);
            chk("instr", bus.instr, w);
            chk("pc_out", bus.pc_out, m_waddr);
            chk("pc_plus4", bus.pc_plus4, m_waddr + 32'd4);
            chk("opcode", 32'(bus.opcode), 32'(w[31:26]));
            chk("funct", 32'(bus.funct), 32'(w[5:0]));
          end
        end
      end
      if (reset) begin
        started = 1'b1; rst_q = 1'b1;
        m_pc = 32'h0; m_req = 1'b0; m_out = 1'b0; m_live = 1'b0; m_have = 1'b0;
      end else if (started) begin
        if (rst_q) begin
          rst_q = 1'b0;
          m_req = 1'b1;
        end else begin
          if (m_req) begin
            m_out = 1'b1; m_live = 1'b1; m_oaddr = m_pc;
          end
          if (bus.redirect_valid) begin
            m_pc = {bus.redirect_pc[31:2], 2'b00};
            m_live = 1'b0;
            m_have = 1'b0;
          end else if (m_have && bus.id_ready) begin
            m_pc = m_pc + 32'd4;
            m_have = 1'b0;
          end
          if (bus.imem_valid && m_out) begin
            m_out = 1'b0;
            if (m_live) begin
              m_have = 1'b1;
              m_waddr = m_oaddr;
            end
          end
          m_req = !m_out && !m_have;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    tcyc++;
  endtask

  task automatic wait_req(output logic [31:0] a);
    int unsigned n;
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("wait_req_timeout", 32'(bus.imem_req), 32'h1);
    a = bus.imem_addr;
  endtask

  task automatic wait_ifv();
    int unsigned n;
    n = 0;
    while (bus.if_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("wait_ifv_timeout", 32'(bus.if_valid), 32'h1);
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = target;
    step();
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int unsigned t0, t1, nreq;
    reset = 1'b1;
    bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    repeat (3) step();
    reset = 1'b0;
    bus.id_ready = 1'b1;

    // Sequential fetch, 1-cycle memory, decoder always ready.
    wait_req(a); chk("t1_addr0", a, 32'h0); t0 = tcyc;
    step();
    wait_req(a); chk("t1_addr1", a, 32'h4); t1 = tcyc;
    chk("t1_interval_a", t1 - t0, 32'd3);
    step();
    wait_req(a); chk("t1_addr2", a, 32'h8); t0 = tcyc;
    chk("t1_interval_b", t0 - t1, 32'd3);

    // Hold the lw word at 0x8.
    bus.id_ready = 1'b0;
    wait_ifv();
    chk("t2_instr", bus.instr, 32'h8C020004);
    chk("t2_opcode", 32'(bus.opcode), 32'h23);
    chk("t2_funct", 32'(bus.funct), 32'h04);
    chk("t2_pc_out", bus.pc_out, 32'h8);
    chk("t2_pc_plus4", bus.pc_plus4, 32'hC);

    nreq = 0;
    repeat (5) begin
      step();
      if (bus.imem_req === 1'b1) nreq++;
    end
    chk("t3_no_req_in_hold", nreq, 32'd0);
    chk("t3_instr_held", bus.instr, 32'h8C020004);
    lat = 3;
    bus.id_ready = 1'b1;
    wait_req(a); chk("t3_next_addr", a, 32'hC);

    // Redirect while waiting on a 3-cycle memory.
    step();
    pulse_redirect(32'h00000043);
    lat = 1;
    wait_req(a); chk("t4_redirect_addr", a, 32'h40);

    // Redirect and id_ready together in HOLD.
    wait_ifv();
    pulse_redirect(32'h00000100);
    wait_req(a); chk("t5_redirect_addr", a, 32'h100);

    // Redirect in REQ cancels the issued request; then wrap past the top of the space.
    pulse_redirect(32'hFFFFFFFE);
    wait_req(a); chk("t6_top_addr", a, 32'hFFFFFFFC);
    step();
    wait_req(a); chk("t6_wrap_addr", a, 32'h0);

    // Redirect in WAIT coinciding with the response.
    step();
    lat = 3;
    pulse_redirect(32'h00000200);
    wait_req(a); chk("wait_valid_redirect", a, 32'h200);

    // Two redirects while draining: the last one wins.
    step();
    pulse_redirect(32'h00000300);
    pulse_redirect(32'h00000344);
    wait_req(a); chk("drain_last_wins", a, 32'h344);

    // Reset while waiting on memory.
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    lat = 1;
    chk("t6_reset_if_valid", 32'(bus.if_valid), 32'h0);
    t0 = tcyc;
    wait_req(a); chk("t6_reset_fetch", a, 32'h0);
    chk("t6_reset_latency", tcyc - t0, 32'd1);

    repeat (8) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
